serial_subtractor4bits: RTL and testbench
=========================================

# serial_subtractor4bits

Bit-serial two's-complement subtractor computing `inA - inB - bin`, one bit position per clock, LSB first. It uses a single full-adder cell internally (A + ~B + ~bin), with a registered carry between positions. It sits beside the combinational ripple adders in the datapath as the area-cheap inverse operation for multi-cycle arithmetic paths. A start/busy/done handshake brackets each operation.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 2..16.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset_n`  input  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  input  1  request; sampled only when `busy` = 0.
- `inA`  input  WIDTH  minuend; latched on an accepted start.
- `inB`  input  WIDTH  subtrahend; latched on an accepted start.
- `bin`  input  1  borrow-in; latched on an accepted start.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse when `diff`/`bout` update.
- `diff`  output  WIDTH  result `(inA - inB - bin) mod 2^WIDTH`.
- `bout`  output  1  borrow-out; 1 iff unsigned `inA < inB + bin`.
- `ovf`  output  1  signed overflow (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE and DONE both accept `start`.
- On an accepted start:
  - latch `inA` and `inB` into shift registers;
  - carry register = `~bin`;
  - bit counter = 0;
  - go to SHIFT.
- SHIFT, each cycle:
  - s = a0 ^ ~b0 ^ c;
  - c' = majority(a0, ~b0, c);
  - shift s into the MSB of the result register;
  - shift the operand registers right by one;
  - counter +1.
- SHIFT exit: the cycle with counter = WIDTH-1 goes to DONE. On that edge:
  - `diff` = assembled result;
  - `bout` = ~c';
  - `ovf` is updated;
  - `done` = 1.
- DONE: `done` = 0 on the next edge unless a new start is accepted; go to IDLE.
- `start` while `busy` = 1 is ignored: no queuing, operands unchanged.
- `diff`, `bout` and `ovf` hold their values until the next completion. They are never exposed mid-operation.
- Reset (`reset_n` = 0 at any edge, including mid-SHIFT):
  - state = IDLE;
  - `busy`, `done`, `diff`, `bout`, `ovf` = 0;
  - any in-flight operation is discarded with no `done` pulse;
  - reset takes priority over `start`.

## Timing
- Start accepted at edge E0 → `busy` = 1 from E0 through E0+WIDTH.
- Bits are processed at edges E0+1 .. E0+WIDTH.
- `done` = 1 and results valid in the cycle after edge E0+WIDTH.
  - `done` stays high for exactly one cycle.
  - `busy` = 0 in that same cycle.
- Latency: WIDTH cycles from the start edge to `done`.
- Back-to-back operation: `start` held high during the `done` cycle is accepted.
  - Throughput is one result per WIDTH+1 cycles.
  - `busy` rises again on the edge that ends the `done` cycle.
- `busy` and `done` are never both 1.

## Configuration
- `SUB_OVERFLOW_EN` defined:
  - at completion, `ovf` = (a_msb != b_msb) && (diff_msb != a_msb), using the latched operand MSBs;
  - those MSBs are kept in dedicated registers.
- `SUB_OVERFLOW_EN` not defined:
  - the `ovf` port remains, tied to constant 0;
  - no MSB registers are built.

## Test plan
- Reset, then `inA`=5, `inB`=3, `bin`=0, start → `busy` for 4 cycles, then `done` pulse with `diff`=2, `bout`=0, `ovf`=0.
- `inA`=3, `inB`=5, `bin`=0 → `diff`=14, `bout`=1. Then `inA`=0, `inB`=0, `bin`=1 → `diff`=15, `bout`=1.
- Start accepted. Two cycles later, pulse start with `inA`=9 → ignored: original result delivered, `done` pulses exactly once.
- Start held continuously high across `done` → results 2 and then 1 (5-3, then 5-4) delivered with `done` pulses 5 cycles apart.
- `reset_n` low for one cycle at the 2nd SHIFT cycle → all outputs 0, no `done` pulse; a subsequent 7-7 yields `diff`=0, `bout`=0.
- With `SUB_OVERFLOW_EN`: `inA`=8 (-8), `inB`=1 → `diff`=7, `ovf`=1, `bout`=0. Without the macro → `ovf`=0.

Source files
------------

// File: rtl/serial_subtractor4bits.sv
// Bit-serial subtractor: inA - inB - bin, one bit per clk, LSB first; optional signed overflow under `SUB_OVERFLOW_EN.
// Latency: WIDTH cycles from the accepted start edge to the done pulse; one result per WIDTH+1 cycles back-to-back.
// Backpressure: start is accepted only while busy is low (IDLE or DONE); a start seen while busy is dropped.
module serial_subtractor4bits #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             c_nxt;
  logic             nb0;
  logic             s;
  logic             accept;
  logic             last;

  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign accept = start && !busy;
  assign last   = (cnt == CW'(WIDTH - 1));

  // Subtraction as A + ~B with the carry seeded by ~bin; borrow-out is the inverted final carry.
  assign nb0     = ~b_sr[0];
  assign s       = a_sr[0] ^ nb0 ^ c;
  assign c_nxt   = (a_sr[0] & nb0) | (a_sr[0] & c) | (nb0 & c);
  assign res_nxt = {s, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_sr  <= inA;
            b_sr  <= inB;
            c     <= ~bin;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          c      <= c_nxt;
          cnt    <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            diff  <= res_nxt;
            bout  <= ~c_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;

  // On the last SHIFT cycle s is the result MSB.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= inA[WIDTH-1];
      b_msb <= inB[WIDTH-1];
    end else if (busy && last) begin
      ovf <= (a_msb != b_msb) && (s != a_msb);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor4bits.sv
// Bench for serial_subtractor4bits: directed literal cases plus randomized traffic
// checked every cycle against a cycle-level arithmetic model.
module tb_serial_subtractor4bits;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  serial_subtractor4bits #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .inA(inA), .inB(inB), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: an operation accepted at an edge produces its result W edges later.
  logic         m_busy, m_done, m_bout, m_ovf;
  logic [W-1:0] m_diff;
  logic [W-1:0] ma, mb;
  logic         mbi;
  logic         m_was_busy;
  int           m_k;
  int           m_tmp;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0; m_k = 0;
    end else begin
      m_was_busy = m_busy;
      m_done = 1'b0;
      if (m_busy) begin
        m_k++;
        if (m_k == W) begin
          m_tmp  = int'(ma) - int'(mb) - int'(mbi);
          m_diff = m_tmp[W-1:0];
          m_bout = (m_tmp < 0);
`ifdef SUB_OVERFLOW_EN
          m_ovf  = (ma[W-1] != mb[W-1]) && (m_diff[W-1] != ma[W-1]);
`else
          m_ovf  = 1'b0;
`endif
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
      if (!m_was_busy && start) begin
        ma = inA; mb = inB; mbi = bin;
        m_busy = 1'b1;
        m_k = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("diff", diff, m_diff);
      check("bout", bout, m_bout);
      check("ovf", ovf, m_ovf);
      check("busy_and_done", busy && done, 1'b0);
    end
  end

  // Caller is at a negedge; drives a one-cycle start and checks the completion.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input logic [W-1:0] ed, input logic eb, input logic eo, input string nm);
    int nb;
    bit got;
    nb = 0;
    got = 1'b0;
    inA = a; inB = b; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    check({nm, "_done_seen"}, got, 1'b1);
    check({nm, "_busy_cycles"}, nb, W);
    check({nm, "_diff"}, diff, ed);
    check({nm, "_bout"}, bout, eb);
    check({nm, "_ovf"}, ovf, eo);
    @(negedge clk);
    check({nm, "_done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    int t1, t2;
    logic [W-1:0] d1, d2;
    logic exp_ovf81;

    reset_n = 1'b0; start = 1'b0; inA = '0; inB = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 4'd0);
    check("rst_bout", bout, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    do_op(4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0, "5m3");
    do_op(4'd3, 4'd5, 1'b0, 4'd14, 1'b1, 1'b0, "3m5");
    do_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, "0m0b");

    // Start while busy is dropped.
    inA = 4'd5; inB = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    inA = 4'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; d1 = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin ndone++; d1 = diff; end
      @(negedge clk);
    end
    check("ignored_done_count", ndone, 1);
    check("ignored_diff", d1, 4'd2);

    // Start held high across done: back-to-back operations.
    inA = 4'd5; inB = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    inB = 4'd4;
    ndone = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0;
    for (int i = 0; i < 20 && ndone < 2; i++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin t1 = cyc; d1 = diff; end
        else begin t2 = cyc; d2 = diff; end
      end
      if (ndone < 2) @(negedge clk);
    end
    start = 1'b0;
    check("b2b_count", ndone, 2);
    check("b2b_first", d1, 4'd2);
    check("b2b_second", d2, 4'd1);
    check("b2b_spacing", t2 - t1, 5);
    repeat (8) @(negedge clk);

    // Reset during the second SHIFT cycle.
    inA = 4'd9; inB = 4'd2; bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_diff", diff, 4'd0);
    check("midrst_bout", bout, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst_no_done", ndone, 0);
    do_op(4'd7, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, "7m7");

`ifdef SUB_OVERFLOW_EN
    exp_ovf81 = 1'b1;
`else
    exp_ovf81 = 1'b0;
`endif
    do_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, exp_ovf81, "8m1");

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      start   = ($urandom_range(0, 2) == 0);
      inA     = W'($urandom);
      inB     = W'($urandom);
      bin     = 1'($urandom);
      @(negedge clk);
    end
    reset_n = 1'b1; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
